// File: rtl/hash_loader_if.sv
// Byte-stream handshake into hash_loader: the source drives valid/data/last
// and the loader answers with a registered ready.
`timescale 1ns/1ps
interface hash_loader_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_last;
    logic       rx_ready;

    modport master (output rx_valid, rx_data, rx_last, input rx_ready);
    modport slave  (input rx_valid, rx_data, rx_last, output rx_ready);
endinterface

// File: rtl/hash_loader.sv
// Assembles a byte stream of NTLM hashes into the flat compare bus and pulses start_bit once the set is complete.
// Optional trailing XOR checksum byte when HASH_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module hash_loader #(
    parameter int NUM_HASHES = 64,
    parameter int HASH_BITS  = 128
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    hash_loader_if.slave                         rx,
    input  logic                                 clear,
    output logic [0:NUM_HASHES*HASH_BITS-1]      allthehashes,
    output logic [$clog2(NUM_HASHES+1)-1:0]      hash_count,
    output logic                                 start_bit,
    output logic                                 load_err,
    output logic                                 busy
);
    localparam int BUS_W = NUM_HASHES * HASH_BITS;
    localparam int BPH   = HASH_BITS / 8;
    localparam int TOTAL = NUM_HASHES * BPH;
    localparam int CNT_W = $clog2(TOTAL);
    localparam int HC_W  = $clog2(NUM_HASHES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [0:BUS_W-1]  bus_q, bus_d;
    logic [HC_W-1:0]   hc_q, hc_d;
    logic              err_q, err_d;
    logic              start_q, start_d;
    logic              ready_q, ready_d;
`ifdef HASH_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic accept, boundary, final_byte;
    int   idx;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bus_d      = bus_q;
        hc_d       = hc_q;
        err_d      = err_q;
        start_d    = 1'b0;
`ifdef HASH_LOADER_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        accept     = rx.rx_valid && ready_q;
        boundary   = ((int'(cnt_q) % BPH) == BPH - 1);
        final_byte = (cnt_q == CNT_W'(TOTAL - 1));
        idx        = 8 * int'(cnt_q);

        // clear wins over a byte accepted on the same edge; that byte is dropped
        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            bus_d   = '0;
            hc_d    = '0;
`ifdef HASH_LOADER_CHECKSUM_EN
            xor_d   = '0;
`endif
        end else if (accept) begin
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (state_q == S_IDLE) err_d = 1'b0;
                    bus_d[idx +: 8] = rx.rx_data;
                    cnt_d           = cnt_q + CNT_W'(1);
                    state_d         = S_LOAD;
`ifdef HASH_LOADER_CHECKSUM_EN
                    xor_d = (state_q == S_IDLE) ? rx.rx_data : (xor_q ^ rx.rx_data);
`endif
                    if (boundary) hc_d = hc_q + HC_W'(1);
                    if (final_byte || (rx.rx_last && boundary)) begin
`ifdef HASH_LOADER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
                        start_d = 1'b1;
`endif
                    end else if (rx.rx_last) begin
                        // a set must end on a hash boundary; anything else is discarded
                        err_d   = 1'b1;
                        bus_d   = '0;
                        hc_d    = '0;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
`ifdef HASH_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (rx.rx_data == xor_q) begin
                        state_d = S_DONE;
                        start_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        bus_d   = '0;
                        hc_d    = '0;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
`endif
                default: ;
            endcase
        end

        ready_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bus_q   <= '0;
            hc_q    <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            ready_q <= 1'b0;
`ifdef HASH_LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            hc_q    <= hc_d;
            err_q   <= err_d;
            start_q <= start_d;
            ready_q <= ready_d;
`ifdef HASH_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign rx.rx_ready   = ready_q;
    assign allthehashes  = bus_q;
    assign hash_count    = hc_q;
    assign start_bit     = start_q;
    assign load_err      = err_q;
    assign busy          = (state_q == S_LOAD);
endmodule

// File: tb/tb_hash_loader.sv
// Self-checking bench for hash_loader: vector table of whole loads plus hand-written clear/reset/DONE sequences.
`timescale 1ns/1ps
module tb_hash_loader;
    localparam int NH = 64;
    localparam int HB = 128;
    localparam int BW = NH * HB;
    localparam int NB = BW / 8;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            clear = 1'b0;
    logic [0:BW-1]   allthehashes;
    logic [6:0]      hash_count;
    logic            start_bit, load_err, busy;

    hash_loader_if rx();

    hash_loader #(.NUM_HASHES(NH), .HASH_BITS(HB)) dut (
        .clk(clk), .n_rst(n_rst), .rx(rx), .clear(clear),
        .allthehashes(allthehashes), .hash_count(hash_count),
        .start_bit(start_bit), .load_err(load_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    logic [7:0] sb_q[$];
    logic [7:0] tb_xor;

    // start_bit sampled just before each rising edge
    always @(posedge clk) if (start_bit === 1'b1) start_cnt++;

    typedef struct {
        int nbytes; int last_at; int pat; bit gaps;
        int exp_cnt; bit exp_err; bit exp_start;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic [0:BW-1] exp);
        int fb;
        total++;
        if (allthehashes !== exp) begin
            bad++;
            fb = -1;
            for (int b = 0; b < NB; b++)
                if (fb < 0 && allthehashes[8*b +: 8] !== exp[8*b +: 8]) fb = b;
            $display("FAIL %s: bus byte %0d got %0h expected %0h", name, fb,
                     allthehashes[8*fb +: 8], exp[8*fb +: 8]);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input bit track, output logic acc);
        @(negedge clk);
        rx.rx_valid = v;
        rx.rx_data  = d;
        rx.rx_last  = l;
        acc = v && (rx.rx_ready === 1'b1);
        if (acc && track) begin
            sb_q.push_back(d);
            tb_xor ^= d;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l, input bit track);
        logic acc;
        int tries;
        tries = 0;
        do begin
            drive(1'b1, d, l, track, acc);
            tries++;
        end while (!acc && tries < 4);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept: byte %0h not taken after 4 cycles", d);
        end
    endtask

    task automatic idle();
        logic acc;
        drive(1'b0, 8'h00, 1'b0, 1'b0, acc);
    endtask

    task automatic send_checksum();
`ifdef HASH_LOADER_CHECKSUM_EN
        send(tb_xor, 1'b0, 1'b0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        clear = 1'b0;
        rx.rx_valid = 1'b0;
        rx.rx_last = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        sb_q.delete();
        tb_xor = 8'h00;
        start_cnt = 0;
        @(negedge clk);
    endtask

    task automatic model_bus(output logic [0:BW-1] exp);
        int b;
        exp = '0;
        b = 0;
        while (sb_q.size() > 0) begin
            exp[8*b +: 8] = sb_q.pop_front();
            b++;
        end
    endtask

    function automatic logic [7:0] pat_byte(input int pat, input int k);
        case (pat)
            0:       return 8'(k);
            1:       return 8'hAA;
            default: return 8'(k * 7 + 3);
        endcase
    endfunction

    logic [0:BW-1] exp_bus;
    logic [0:BW-1] saved_bus;
    logic          acc;

    initial begin
        rx.rx_valid = 1'b0;
        rx.rx_data  = 8'h00;
        rx.rx_last  = 1'b0;
        tb_xor      = 8'h00;

        vecs[0] = '{1024, -1, 0, 1'b0, 64, 1'b0, 1'b1};
        vecs[1] = '{48,   47, 1, 1'b0, 3,  1'b0, 1'b1};
        vecs[2] = '{21,   20, 0, 1'b0, 0,  1'b1, 1'b0};
        vecs[3] = '{32,   31, 2, 1'b1, 2,  1'b0, 1'b1};

        #2;
        chk("rst_ready", rx.rx_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", start_bit, 0);
        chk("rst_err", load_err, 0);
        chk("rst_count", hash_count, 0);
        chk_bus("rst_bus", '0);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            for (int k = 0; k < vecs[i].nbytes; k++) begin
                if (vecs[i].gaps && (k % 2 == 1))
                    drive(1'b0, 8'hEE, 1'b1, 1'b1, acc);
                send(pat_byte(vecs[i].pat, k), (k == vecs[i].last_at), 1'b1);
            end
            if (!vecs[i].exp_err) send_checksum();
            idle();
            chk($sformatf("v%0d_start_pulse", i), start_bit, vecs[i].exp_start);
            idle();
            chk($sformatf("v%0d_start_width", i), start_bit, 0);
            chk($sformatf("v%0d_start_cnt", i), start_cnt, vecs[i].exp_start);
            chk($sformatf("v%0d_count", i), hash_count, vecs[i].exp_cnt);
            chk($sformatf("v%0d_err", i), load_err, vecs[i].exp_err);
            chk($sformatf("v%0d_busy", i), busy, 0);
            chk($sformatf("v%0d_ready", i), rx.rx_ready, !vecs[i].exp_start);
            model_bus(exp_bus);
            if (vecs[i].exp_err) exp_bus = '0;
            chk_bus($sformatf("v%0d_bus", i), exp_bus);

            if (i == 0) begin
                chk("full_first", allthehashes[0:7], 8'h00);
                chk("full_fe", allthehashes[8176:8183], 8'hFE);
                chk("full_ff", allthehashes[8184:8191], 8'hFF);
            end
            if (i == 2) begin
                send(8'h55, 1'b0, 1'b1);
                idle();
                chk("err_cleared", load_err, 0);
                chk("err_reload_busy", busy, 1);
            end
            if (i == 3) begin
                saved_bus = allthehashes;
                for (int j = 0; j < 5; j++) begin
                    drive(1'b1, 8'h77, 1'b0, 1'b1, acc);
                    chk("done_ignore_acc", acc, 0);
                end
                idle();
                chk_bus("done_bus_frozen", saved_bus);
                chk("done_count_frozen", hash_count, 2);
                chk("done_no_restart", start_cnt, 1);
            end
        end

        // clear with a simultaneous valid byte at k=100
        do_reset();
        for (int k = 0; k < 100; k++) send(8'(k + 1), 1'b0, 1'b1);
        drive(1'b1, 8'h5A, 1'b0, 1'b0, acc);
        clear = 1'b1;
        idle();
        clear = 1'b0;
        chk_bus("clr_bus", '0);
        chk("clr_count", hash_count, 0);
        chk("clr_busy", busy, 0);
        chk("clr_ready", rx.rx_ready, 1);
        chk("clr_err_kept", load_err, 0);
        chk("clr_no_start", start_cnt, 0);
        sb_q.delete();
        tb_xor = 8'h00;
        for (int k = 0; k < 16; k++) send(8'(8'hC0 + k), (k == 15), 1'b1);
        send_checksum();
        idle();
        idle();
        chk("clr_reload_count", hash_count, 1);
        chk("clr_reload_start", start_cnt, 1);
        model_bus(exp_bus);
        chk_bus("clr_reload_bus", exp_bus);

        // asynchronous reset in the middle of a load
        do_reset();
        for (int k = 0; k < 500; k++) send(8'(k ^ 8'h3C), 1'b0, 1'b1);
        #2;
        n_rst = 1'b0;
        #1;
        chk_bus("arst_bus", '0);
        chk("arst_count", hash_count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", rx.rx_ready, 0);
        chk("arst_start", start_bit, 0);
        chk("arst_err", load_err, 0);
        rx.rx_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("arst_no_start", start_cnt, 0);
        chk("arst_ready_rise", rx.rx_ready, 1);

`ifdef HASH_LOADER_CHECKSUM_EN
        do_reset();
        for (int k = 0; k < 16; k++) send(8'(k + 1), (k == 15), 1'b1);
        send(8'h10, 1'b0, 1'b0);
        idle();
        chk("cs_good_start", start_bit, 1);
        idle();
        chk("cs_good_err", load_err, 0);
        chk("cs_good_count", hash_count, 1);
        do_reset();
        for (int k = 0; k < 16; k++) send(8'(k + 1), (k == 15), 1'b1);
        send(8'h11, 1'b0, 1'b0);
        idle();
        chk("cs_bad_start", start_bit, 0);
        idle();
        chk("cs_bad_err", load_err, 1);
        chk("cs_bad_busy", busy, 0);
        chk("cs_bad_nostart", start_cnt, 0);
        chk_bus("cs_bad_bus", '0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hash_loader.md
Name: hash_loader

Overview:
- Upstream feeder for the cracking controller. Receives target NTLM hashes as a byte stream and assembles them into the flat hash bus that the compare stage consumes.
- Issues a one-cycle start_bit to the guess generator once the hash set is complete, then freezes the bus until cleared.
- Unloaded hash slots are zero-filled.

Parameters:
- NUM_HASHES, 64, number of 128-bit hash slots; bus width = NUM_HASHES*HASH_BITS.
- HASH_BITS, 128, bits per hash; must be a multiple of 8.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- rx_valid  in  1  input byte valid.
- rx_data  in  8  input byte.
- rx_last  in  1  qualifies rx_data as the final byte of the set.
- rx_ready  out  1  loader accepts a byte this cycle (registered).
- clear  in  1  synchronous abort/unfreeze.
- allthehashes  out  NUM_HASHES*HASH_BITS, [0:8191] at defaults  assembled hash bus.
- hash_count  out  7  number of complete hashes loaded (0..64).
- start_bit  out  1  one-cycle pulse when the set is complete.
- load_err  out  1  sticky error flag.
- busy  out  1  high while in LOAD.

Behaviour:
- Reset values (async, n_rst low):
  - state=IDLE; byte counter=0.
  - allthehashes, hash_count, start_bit, load_err, busy, rx_ready all 0.
  - rx_ready rises on the first clk edge after reset release.
- Accept rule: a byte is taken only when rx_valid && rx_ready on a clk edge.
- Byte packing: accepted byte k (k = 0..1023) lands in allthehashes[8k:8k+7]. Hash 0 MSB byte arrives first. No reordering here; the downstream compare expects this order.
- Byte counter: 10 bits. hash_count = completed hashes, updated on each accepted byte with k%16==15.
- IDLE:
  - rx_ready=1; load_err holds its value.
  - First accepted byte -> LOAD; the byte is stored and load_err is cleared.
- LOAD:
  - rx_ready=1, busy=1.
  - Accepted byte with k==1023 -> DONE. rx_last is don't-care on this byte.
  - Accepted byte with rx_last=1 and k%16==15 -> DONE; slots not written stay 0.
  - Accepted byte with rx_last=1 and k%16!=15 -> load_err=1, bus and count zeroed, -> IDLE.
- DONE:
  - rx_ready=0, busy=0; allthehashes and hash_count frozen.
  - start_bit=1 in the first DONE cycle only, i.e. the cycle after the final byte edge.
  - Bytes presented in DONE are ignored.
- clear:
  - In any state: next edge zeroes bus, count and counter, and goes to IDLE. load_err is left unchanged.
  - clear has priority over a simultaneous accepted byte; that byte is dropped.
  - clear in the start_bit cycle suppresses nothing already issued.
- Counter wrap: impossible, because the transition at k==1023 leaves LOAD.
- Reset mid-load: immediate return to reset values; no start_bit.
- rx_data/rx_last with rx_valid=0: ignored.

Optional Feature:
- Macro: HASH_LOADER_CHECKSUM_EN.
- Defined:
  - The set is followed by one extra checksum byte equal to the XOR of all data bytes.
  - The final data byte, at k==1023 or on a hash boundary with rx_last, enters a CHECK state instead of DONE. CHECK has rx_ready=1 and rx_last is don't-care.
  - The next accepted byte is compared. Equal -> DONE plus the start_bit pulse. Unequal -> load_err=1, bus zeroed, IDLE, no start_bit.
  - clear applies in CHECK as in the other states.
- Undefined: no CHECK state, no checksum byte, behaviour as above.

Test Plan:
- Full load: reset, 1024 bytes with byte k = k[7:0] at rx_valid=1 every cycle. Required: allthehashes[0:7]=0x00, [8176:8183]=0xFE, [8184:8191]=0xFF; hash_count=64; start_bit high exactly one cycle, one cycle after the last byte; rx_ready=0 after.
- Partial load: 48 bytes 0xAA with rx_last on byte 47. Required: hash_count=3; bits [0:383]=all 0xAA; bits [384:8191]=0; one start_bit pulse.
- Misaligned last: rx_last on byte 20. Required: load_err=1; state IDLE; allthehashes=0; no start_bit; next accepted byte clears load_err.
- Backpressure/gaps: rx_valid toggled 1,0,1 across 32 bytes with rx_last on byte 31. Required: only valid bytes stored; hash_count=2. Then 5 bytes sent in DONE are ignored and the bus is unchanged.
- Clear and reset: clear asserted with a valid byte at k=100. Required: byte dropped; bus 0; IDLE. Separately, n_rst pulsed low at k=500: all outputs 0 asynchronously.
- Checksum (macro defined): 16 bytes 0x01..0x10 with rx_last, then 0x10. Required: start_bit pulses. Repeating with checksum 0x11 gives load_err=1 and no start_bit.
